mem_responder: RTL and testbench

Memory-side responder for the core's `imem`/`dmem` request/response interface. It is a word-organised synchronous scratchpad that accepts read and write requests (`fcn`, `typ`, `addr`, `data`) and returns response data after a fixed latency. It performs byte, halfword and word access with sign or zero extension. One instance sits behind each of the core's memory ports in simulation and synthesis test harnesses.

---
 rtl/mem_responder.sv | 174 +++++++++++++++++
 tb/tb_mem_responder.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: word-organised synchronous scratchpad behind a core imem/dmem port.
// Accepts byte/halfword/word reads and writes and returns sign- or zero-extended
// read data (0 for writes) after a fixed LATENCY through a registered valid/data pipe.
// Optional feature macro: MEM_STALL_EN -- periodically drops req_ready, once every
// STALL_PERIOD cycles, driven by a free-running counter.
module mem_responder #(
  parameter int DEPTH_LOG2   = 14,
  parameter int LATENCY      = 1,
  parameter int STALL_PERIOD = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_bits_addr,
  input  logic [31:0] req_bits_data,
  input  logic        req_bits_fcn,
  input  logic [2:0]  req_bits_typ,
  output logic        resp_valid,
  output logic [31:0] resp_bits_data
);

  localparam int WORDS = 1 << DEPTH_LOG2;

  // Access width; typ codes 0, 4 and 7 fall through to a full word.
  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } size_e;

  logic [31:0]           mem [WORDS];
  logic                  accept;
  logic                  stall;
  logic [DEPTH_LOG2-1:0] word_idx;
  logic [1:0]            lane;
  size_e                 size;
  logic                  sign_ext;
  logic [3:0]            wmask;
  logic [31:0]           wdata;
  logic [31:0]           rd_word;
  logic [7:0]            rd_byte;
  logic [15:0]           rd_half;
  logic [31:0]           resp_in;
  logic [LATENCY-1:0]    pipe_valid;
  logic [31:0]           pipe_data [LATENCY];

  // Address bits above the memory size are ignored, so accesses wrap.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_bits_addr[31:DEPTH_LOG2+2];

  assign word_idx = req_bits_addr[DEPTH_LOG2+1:2];
  assign lane     = req_bits_addr[1:0];
  assign accept   = req_valid && req_ready;

`ifdef MEM_STALL_EN
  localparam int CW = (STALL_PERIOD > 2) ? $clog2(STALL_PERIOD) : 1;
  localparam logic [CW-1:0] STALL_LAST = CW'(STALL_PERIOD - 1);

  logic [CW-1:0] stall_cnt;

  // Free-running stall counter 0..STALL_PERIOD-1, independent of req_valid.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall_cnt == STALL_LAST) begin
      stall_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign stall = (stall_cnt == STALL_LAST);
`else
  logic unused_stall_cfg;
  assign unused_stall_cfg = (STALL_PERIOD > 1);
  assign stall = 1'b0;
`endif

  // Ready depends only on reset and the stall phase, never on req_valid.
  assign req_ready = !reset && !stall;

  // Decode the request type into access width and extension mode.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    size     = SZ_W;
    sign_ext = 1'b0;
    case (req_bits_typ)
      3'd1: begin size = SZ_B; sign_ext = 1'b1; end
      3'd2: begin size = SZ_H; sign_ext = 1'b1; end
      3'd5: size = SZ_B;
      3'd6: size = SZ_H;
      default: size = SZ_W;
    endcase
  end

  // Byte-lane enables and lane-replicated store data; alignment is forced.
  always_comb begin
    wmask = 4'b1111;
    wdata = req_bits_data;
    case (size)
      SZ_B: begin
        wmask = 4'b0001 << lane;
        wdata = {4{req_bits_data[7:0]}};
      end
      SZ_H: begin
        wmask = lane[1] ? 4'b1100 : 4'b0011;
        wdata = {2{req_bits_data[15:0]}};
      end
      default: begin
        wmask = 4'b1111;
        wdata = req_bits_data;
      end
    endcase
  end

  // Lane extraction and extension of the word read at the acceptance edge.
  always_comb begin
    rd_word = mem[word_idx];
    rd_byte = rd_word[8*lane +: 8];
    rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
    resp_in = rd_word;
    case (size)
      SZ_B:    resp_in = sign_ext ? {{24{rd_byte[7]}}, rd_byte} : {24'd0, rd_byte};
      SZ_H:    resp_in = sign_ext ? {{16{rd_half[15]}}, rd_half} : {16'd0, rd_half};
      default: resp_in = rd_word;
    endcase
    if (req_bits_fcn) begin
      resp_in = '0;
    end
  end

  // Byte-masked store into the scratchpad on an accepted write.
  always_ff @(posedge clock) begin
    // NOTE: the storage array is deliberately left out of reset; contents survive
    // a reset and power up undefined, which keeps it mappable onto RAM.
    if (accept && req_bits_fcn) begin
      for (int i = 0; i < 4; i++) begin
        if (wmask[i]) begin
          mem[word_idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  // LATENCY-deep response pipe; data stages load only behind a valid so the
  // output data holds its last value between responses.
  always_ff @(posedge clock) begin
    if (reset) begin
      pipe_valid <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        pipe_data[i] <= '0;
      end
    end else begin
      pipe_valid[0] <= accept;
      if (accept) begin
        pipe_data[0] <= resp_in;
      end
      for (int i = 1; i < LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        if (pipe_valid[i-1]) begin
          pipe_data[i] <= pipe_data[i-1];
        end
      end
    end
  end

  assign resp_valid     = pipe_valid[LATENCY-1];
  assign resp_bits_data = pipe_data[LATENCY-1];

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized and directed stimulus against a byte-array model
// of the scratchpad with a due-cycle response queue, compared every cycle.
module tb_mem_responder;

  localparam int DL     = 4;
  localparam int LAT    = 3;
  localparam int SP     = 4;
  localparam int NBYTES = 4 << DL;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_bits_addr;
  logic [31:0] req_bits_data;
  logic        req_bits_fcn;
  logic [2:0]  req_bits_typ;
  logic        resp_valid;
  logic [31:0] resp_bits_data;

  always #5 clock = ~clock;

  mem_responder #(
    .DEPTH_LOG2  (DL),
    .LATENCY     (LAT),
    .STALL_PERIOD(SP)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_bits_addr (req_bits_addr),
    .req_bits_data (req_bits_data),
    .req_bits_fcn  (req_bits_fcn),
    .req_bits_typ  (req_bits_typ),
    .resp_valid    (resp_valid),
    .resp_bits_data(resp_bits_data)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at cycle", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int          due;
    logic [31:0] data;
  } resp_t;

  logic [7:0]  mm [NBYTES];
  resp_t       q[$];
  int          cyc       = 0;
  int          since_rst = 0;
  bit          last_acc  = 1'b0;
  logic [31:0] exp_data  = '0;
  bit          exp_v;

  function automatic int acc_size(input logic [2:0] typ);
    case (typ)
      3'd1, 3'd5: return 1;
      3'd2, 3'd6: return 2;
      default:    return 4;
    endcase
  endfunction

  function automatic int base_of(input logic [2:0] typ, input logic [31:0] addr);
    int b;
    b = int'(addr % NBYTES);
    return b - (b % acc_size(typ));
  endfunction

  function automatic logic [31:0] model_read(input logic [2:0] typ, input logic [31:0] addr);
    logic [31:0] v;
    int n, b;
    n = acc_size(typ);
    b = base_of(typ, addr);
    v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = mm[b + i];
    if (typ == 3'd1) v = {{24{v[7]}}, v[7:0]};
    if (typ == 3'd2) v = {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  function automatic void model_write(input logic [2:0] typ, input logic [31:0] addr,
                                      input logic [31:0] data);
    int n, b;
    n = acc_size(typ);
    b = base_of(typ, addr);
    for (int i = 0; i < n; i++) mm[b + i] = data[8*i +: 8];
  endfunction

  function automatic bit ready_now();
    if (reset) return 1'b0;
`ifdef MEM_STALL_EN
    return (since_rst % SP) != (SP - 1);
`else
    return 1'b1;
`endif
  endfunction

  // Model update at each edge, then compare the DUT just after it.
  always begin
    @(posedge clock);
    last_acc = 1'b0;
    if (reset) begin
      q.delete();
      since_rst = 0;
      exp_data  = '0;
    end else begin
      if (req_valid && ready_now()) begin
        logic [31:0] r;
        last_acc = 1'b1;
        r = req_bits_fcn ? 32'd0 : model_read(req_bits_typ, req_bits_addr);
        if (req_bits_fcn) model_write(req_bits_typ, req_bits_addr, req_bits_data);
        q.push_back('{due: cyc + LAT, data: r});
      end
      since_rst++;
    end
    cyc++;
    #1;
    exp_v = (q.size() > 0) && (q[0].due == cyc);
    if (exp_v) begin
      exp_data = q[0].data;
      void'(q.pop_front());
    end
    check("resp_valid", {31'd0, resp_valid}, {31'd0, exp_v});
    check("resp_data", resp_bits_data, exp_data);
    check("req_ready", {31'd0, req_ready}, {31'd0, ready_now()});
  end

  // ---------------- drivers ----------------
  task automatic send(input logic fcn, input logic [2:0] typ, input logic [31:0] addr,
                      input logic [31:0] data);
    int n;
    req_valid     = 1'b1;
    req_bits_fcn  = fcn;
    req_bits_typ  = typ;
    req_bits_addr = addr;
    req_bits_data = data;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!last_acc && n < 20);
    if (!last_acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=not accepted required=accepted addr=%h", addr);
    end
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // A write held during reset must never be accepted.
    reset         = 1'b1;
    req_valid     = 1'b1;
    req_bits_fcn  = 1'b1;
    req_bits_typ  = 3'd3;
    req_bits_addr = 32'h8;
    req_bits_data = 32'hBAD0BAD0;
    repeat (3) @(negedge clock);
    reset     = 1'b0;
    req_valid = 1'b0;

    // Preload every word with its own byte address.
    for (int w = 0; w < NBYTES / 4; w++) send(1'b1, 3'd3, 32'(w * 4), 32'(w * 4));
    check("model_preload", model_read(3'd3, 32'h8), 32'h8);
    send(1'b0, 3'd3, 32'h8, 32'h0);

    // Word write then read.
    send(1'b1, 3'd3, 32'h100, 32'hDEADBEEF);
    send(1'b0, 3'd3, 32'h100, 32'h0);
    check("model_word", model_read(3'd3, 32'h100), 32'hDEADBEEF);
    idle(2);

    // Sub-word writes and extension.
    send(1'b1, 3'd3, 32'h200, 32'h0);
    send(1'b1, 3'd1, 32'h201, 32'h80);
    send(1'b1, 3'd2, 32'h202, 32'h1234);
    send(1'b0, 3'd1, 32'h201, 32'h0);
    send(1'b0, 3'd5, 32'h201, 32'h0);
    send(1'b0, 3'd2, 32'h202, 32'h0);
    send(1'b0, 3'd3, 32'h200, 32'h0);
    check("model_b",  model_read(3'd1, 32'h201), 32'hFFFFFF80);
    check("model_bu", model_read(3'd5, 32'h201), 32'h00000080);
    check("model_h",  model_read(3'd2, 32'h202), 32'h00001234);
    check("model_w",  model_read(3'd3, 32'h200), 32'h12348000);

    // Back-to-back reads of words preloaded with their own address.
    send(1'b1, 3'd3, 32'h0, 32'h0);
    for (int i = 0; i < 4; i++) send(1'b0, 3'd3, 32'(i * 4), 32'h0);
    check("model_pipe", model_read(3'd3, 32'hC), 32'hC);
    idle(LAT + 1);

    // Wrap-around and forced halfword alignment.
    send(1'b1, 3'd3, 32'h40, 32'hA5A5A5A5);
    send(1'b0, 3'd3, 32'h0, 32'h0);
    send(1'b0, 3'd2, 32'h3, 32'h0);
    send(1'b0, 3'd6, 32'h3, 32'h0);
    check("model_wrap", model_read(3'd3, 32'h0), 32'hA5A5A5A5);
    check("model_h3",   model_read(3'd2, 32'h3), 32'hFFFFA5A5);
    check("model_hu3",  model_read(3'd6, 32'h3), 32'h0000A5A5);

    // Reset mid-flight: in-flight read dropped, earlier write kept.
    send(1'b1, 3'd3, 32'h14, 32'h5555AAAA);
    send(1'b0, 3'd3, 32'h4, 32'h0);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    send(1'b0, 3'd3, 32'h14, 32'h0);
    check("model_keep", model_read(3'd3, 32'h14), 32'h5555AAAA);
    idle(LAT + 1);

    // Randomized traffic with occasional resets and idle gaps.
    repeat (1500) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        req_valid     = 1'(($urandom_range(0, 1)));
        req_bits_fcn  = 1'b1;
        req_bits_typ  = 3'($urandom_range(0, 7));
        req_bits_addr = $urandom;
        req_bits_data = $urandom;
        reset         = 1'b1;
        repeat (int'($urandom_range(1, 2))) @(negedge clock);
        reset     = 1'b0;
        req_valid = 1'b0;
      end else if (r < 20) begin
        idle(int'($urandom_range(1, 3)));
      end else begin
        send(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom);
      end
    end

    idle(LAT + 2);
    check("drain", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
